wb_writer: RTL and testbench

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_writer_if.sv | 36 +++
 rtl/wb_writer.sv | 86 ++++++++
 tb/tb_wb_writer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_writer_if.sv
// Execute-to-writeback result bus, register-file write port and decoder bypass port.
// The slave modport is the writeback buffer; the master modport is its environment.
interface wb_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [4:0]  in_rd;
    logic [31:0] in_data;

    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ready;

    logic [4:0]  byp_raddr;
    logic        byp_hit;
    logic [31:0] byp_data;

    modport slave (
        input  in_valid, in_wen, in_rd, in_data,
        output in_ready,
        output rf_wen, rf_waddr, rf_wdata,
        input  rf_ready,
        input  byp_raddr,
        output byp_hit, byp_data
    );

    modport master (
        output in_valid, in_wen, in_rd, in_data,
        input  in_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        output rf_ready,
        output byp_raddr,
        input  byp_hit, byp_data
    );
endinterface

// File: rtl/wb_writer.sv
// Writeback result buffer: in-order FIFO of {wen, rd, data} draining into the register
// file, with a bypass lookup over the buffered pending writes.
module wb_writer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    wb_writer_if.slave   bus,
    output logic [31:0]  retire_cnt,
    output logic         busy
);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic          mem_wen  [DEPTH];
    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   retire_q;

    logic          push;
    logic          pop;
    logic          head_eff;

    assign busy       = (count != '0);
    assign retire_cnt = retire_q;
    assign head_eff   = mem_wen[rd_ptr] && (mem_rd[rd_ptr] != 5'd0);

    assign bus.in_ready = !rst && (count < DEPTH_C);
    assign bus.rf_wen   = !rst && busy && head_eff;
    assign bus.rf_waddr = mem_rd[rd_ptr];
    assign bus.rf_wdata = mem_data[rd_ptr];

    assign push = bus.in_valid && bus.in_ready;
    // Writes to x0 and retire-only results drain without waiting on the register file.
    assign pop  = !rst && busy && (!head_eff || bus.rf_ready);

    // Scan oldest to newest so the last match is the newest pending write.
    always_comb begin
        logic [AW-1:0] idx;
        idx          = '0;
        bus.byp_hit  = 1'b0;
        bus.byp_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (((AW+1)'(i) < count) && mem_wen[idx] && (mem_rd[idx] != 5'd0) &&
                (mem_rd[idx] == bus.byp_raddr)) begin
                bus.byp_hit  = 1'b1;
                bus.byp_data = mem_data[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_wen[wr_ptr]  <= bus.in_wen;
            mem_rd[wr_ptr]   <= bus.in_rd;
            mem_data[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            retire_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                retire_q <= retire_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: a scoreboard of expected register-file writes is filled
// as results are pushed and drained as the register file accepts writes.
module tb_wb_writer;
    logic        clk;
    logic        rst;
    logic [31:0] retire_cnt;
    logic        busy;

    wb_writer_if bus ();

    wb_writer #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .retire_cnt (retire_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [36:0] sb [$];
    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Settle, account for this cycle's push and register-file write, then cross the edge.
    task automatic tick();
        logic [36:0] e;
        #1;
        if (bus.rf_wen && bus.rf_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 32'(bus.rf_waddr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rf_waddr", 32'(bus.rf_waddr), 32'(e[36:32]));
                chk("rf_wdata", bus.rf_wdata, e[31:0]);
            end
        end
        if (bus.in_valid && bus.in_ready && bus.in_wen && (bus.in_rd != 5'd0)) begin
            sb.push_back({bus.in_rd, bus.in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_wen   = w;
        bus.in_rd    = rd;
        bus.in_data  = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rf_ready  = 1'b0;
        bus.byp_raddr = 5'd0;
        @(posedge clk);
        #1;
        tick();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_rf_wen", 32'(bus.rf_wen), 32'd0);

        rst = 1'b0;
        #1;
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_reset_byp_hit", 32'(bus.byp_hit), 32'd0);
        chk("post_reset_byp_data", bus.byp_data, 32'd0);
        chk("post_reset_retire", retire_cnt, 32'd0);

        // Single effective write, one cycle latency
        bus.rf_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'h0000_0007);
        #1;
        chk("no_passthrough", 32'(bus.rf_wen), 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.byp_raddr = 5'd5;
        #1;
        chk("single_rf_wen", 32'(bus.rf_wen), 32'd1);
        chk("single_byp_hit", 32'(bus.byp_hit), 32'd1);
        chk("single_byp_data", bus.byp_data, 32'h0000_0007);
        tick();
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_retire", retire_cnt, 32'd1);
        chk("single_sb_empty", sb.size(), 32'd0);

        // x0 write and retire-only result never reach the register file
        drive(1'b1, 1'b1, 5'd0, 32'h0000_1234);
        tick();
        bus.byp_raddr = 5'd0;
        #1;
        chk("x0_rf_wen", 32'(bus.rf_wen), 32'd0);
        chk("x0_byp_hit", 32'(bus.byp_hit), 32'd0);
        drive(1'b1, 1'b0, 5'd3, 32'd9);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.byp_raddr = 5'd3;
        #1;
        chk("retire_only_rf_wen", 32'(bus.rf_wen), 32'd0);
        chk("retire_only_byp_hit", 32'(bus.byp_hit), 32'd0);
        tick();
        chk("ineffective_busy", 32'(busy), 32'd0);
        chk("ineffective_retire", retire_cnt, 32'd3);

        // Fill with rf_ready low, newest-match bypass, then in-order drain
        bus.rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 32'h0000_000A);
        tick();
        drive(1'b1, 1'b1, 5'd1, 32'h0000_000B);
        tick();
        drive(1'b1, 1'b1, 5'd2, 32'h0000_000C);
        bus.byp_raddr = 5'd1;
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_byp_hit", 32'(bus.byp_hit), 32'd1);
        chk("full_byp_data", bus.byp_data, 32'h0000_000B);
        chk("stall_rf_wen", 32'(bus.rf_wen), 32'd1);
        chk("stall_waddr", 32'(bus.rf_waddr), 32'd1);
        chk("stall_wdata", bus.rf_wdata, 32'h0000_000A);
        tick();
        chk("stall_hold_wdata", bus.rf_wdata, 32'h0000_000A);
        chk("stall_hold_retire", retire_cnt, 32'd3);
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rf_ready = 1'b1;
        tick();
        tick();
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_retire", retire_cnt, 32'd5);
        chk("drain_sb_empty", sb.size(), 32'd0);

        // Streaming: one write per cycle once the first result lands
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'(i * 16 + 3));
            #1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            if (i > 1) chk("stream_rf_wen", 32'(bus.rf_wen), 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("stream_last_rf_wen", 32'(bus.rf_wen), 32'd1);
        tick();
        chk("stream_busy", 32'(busy), 32'd0);
        chk("stream_retire", retire_cnt, 32'd15);
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Reset while full and stalled
        bus.rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 32'h0000_0044);
        tick();
        drive(1'b1, 1'b1, 5'd6, 32'h0000_0066);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        chk("midrst_rf_wen", 32'(bus.rf_wen), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        sb.delete();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.byp_raddr = 5'd4;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_retire", retire_cnt, 32'd0);
        chk("midrst_byp_hit", 32'(bus.byp_hit), 32'd0);
        chk("midrst_byp_data", bus.byp_data, 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.rf_ready = 1'b1;
        tick();
        tick();
        chk("midrst_still_idle", retire_cnt, 32'd0);

        // Retire counter wrap from a preloaded all-ones value
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        chk("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        chk("wrap_before_pop", retire_cnt, 32'hFFFF_FFFF);
        tick();
        chk("wrap_to_zero", retire_cnt, 32'd0);
        chk("wrap_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
